// File: rtl/stride2_window_reader_if.sv
// Bundles the feature-map RAM read port and the tap stream.
// master: the window reader; slave: the RAM/consumer side.
interface stride2_window_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] win_data;
  logic              win_valid;
  logic              win_ready;
  logic              win_last_tap;
  logic              win_last;

  modport master (
    output ram_en, ram_addr, win_data, win_valid, win_last_tap, win_last,
    input  ram_dout, win_ready
  );

  modport slave (
    input  ram_en, ram_addr, win_data, win_valid, win_last_tap, win_last,
    output ram_dout, win_ready
  );
endinterface

// File: rtl/stride2_window_reader.sv
// Streams every KxK window of every map, stepping STRIDE in both axes,
// as one tap per handshake. Reads go through a one-cycle-latency RAM and
// land in a 2-entry FIFO. When the FIFO is empty, arriving data bypasses it,
// so a tap can leave in the same cycle its data returns.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing tap reads while the FIFO has room
// DRAIN | all reads issued, waiting for the final tap to handshake
module stride2_window_reader #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int MAP_W    = 9,
  parameter int MAP_H    = 9,
  parameter int NUM_MAPS = 2,
  parameter int K        = 3,
  parameter int STRIDE   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  stride2_window_reader_if.master bus
);

  localparam int OW  = (MAP_W - K) / STRIDE + 1;
  localparam int OH  = (MAP_H - K) / STRIDE + 1;
  localparam int KW  = $clog2(K + 1);
  localparam int OXW = $clog2(OW + 1);
  localparam int OYW = $clog2(OH + 1);
  localparam int MW  = $clog2(NUM_MAPS + 1);

  localparam logic [ADDR_W-1:0] MAP_STEP = ADDR_W'(MAP_W * MAP_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * MAP_W);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] KY_STEP  = ADDR_W'(MAP_W);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;

  logic [KW-1:0]     kx, ky;
  logic [OXW-1:0]    ox;
  logic [OYW-1:0]    oy;
  logic [MW-1:0]     m;
  logic [ADDR_W-1:0] map_base, row_base, col_base, ky_off;
  logic [ADDR_W-1:0] cur_addr;
  logic              kx_wrap, ky_wrap, ox_wrap, oy_wrap, m_wrap;
  logic              cur_last_tap, cur_last;

  logic              ram_en_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              iss_last_tap, iss_last;
  logic              rd_pend, arr_last_tap, arr_last;

  logic [DATA_W+1:0] fifo_mem [2];
  logic              wptr, rptr;
  logic [1:0]        fifo_cnt, cnt_nxt;
  logic [DATA_W+1:0] head;

  logic              out_valid, out_last_tap, out_last;
  logic [DATA_W-1:0] out_data;
  logic              pop, fifo_pop, push, room, fire;

  // Current tap address from the running bases; only adders, no multipliers.
  always_comb begin
    kx_wrap      = (kx == KW'(K - 1));
    ky_wrap      = (ky == KW'(K - 1));
    ox_wrap      = (ox == OXW'(OW - 1));
    oy_wrap      = (oy == OYW'(OH - 1));
    m_wrap       = (m == MW'(NUM_MAPS - 1));
    cur_last_tap = kx_wrap & ky_wrap;
    cur_last     = cur_last_tap & ox_wrap & oy_wrap & m_wrap;
    cur_addr     = map_base + row_base + ky_off + col_base + ADDR_W'(kx);
  end

  // FIFO head/bypass selection, handshake and read-issue decision.
  always_comb begin
    head      = fifo_mem[rptr];
    out_valid = (fifo_cnt != 2'd0) | rd_pend;
    if (fifo_cnt != 2'd0) begin
      out_data     = head[DATA_W-1:0];
      out_last_tap = head[DATA_W];
      out_last     = head[DATA_W+1];
    end else if (rd_pend) begin
      out_data     = bus.ram_dout;
      out_last_tap = arr_last_tap;
      out_last     = arr_last;
    end else begin
      out_data     = '0;
      out_last_tap = 1'b0;
      out_last     = 1'b0;
    end
    pop      = out_valid & bus.win_ready;
    fifo_pop = pop & (fifo_cnt != 2'd0);
    push     = rd_pend & ~(pop & (fifo_cnt == 2'd0));
    cnt_nxt  = fifo_cnt + {1'b0, push} - {1'b0, fifo_pop};
    // Next cycle's occupancy plus the read landing then must leave a slot.
    room     = ({1'b0, cnt_nxt} + {2'b0, ram_en_q}) < 3'd2;
    fire     = ((state == IDLE) & start & ~done) | ((state == FETCH) & room);
  end

  assign bus.ram_en       = ram_en_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.win_data     = out_data;
  assign bus.win_valid    = out_valid;
  assign bus.win_last_tap = out_last_tap;
  assign bus.win_last     = out_last;

  // Pass sequencing; done is raised as the final tap leaves, so it lands one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            state <= cur_last ? DRAIN : FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (fire && cur_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Loop counters m/oy/ox/ky/kx with matching address bases; all wrap to zero after the last tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0; ky <= '0; ox <= '0; oy <= '0; m <= '0;
      map_base <= '0; row_base <= '0; col_base <= '0; ky_off <= '0;
    end else if (fire) begin
      if (!kx_wrap) begin
        kx <= kx + 1'b1;
      end else begin
        kx <= '0;
        if (!ky_wrap) begin
          ky     <= ky + 1'b1;
          ky_off <= ky_off + KY_STEP;
        end else begin
          ky     <= '0;
          ky_off <= '0;
          if (!ox_wrap) begin
            ox       <= ox + 1'b1;
            col_base <= col_base + COL_STEP;
          end else begin
            ox       <= '0;
            col_base <= '0;
            if (!oy_wrap) begin
              oy       <= oy + 1'b1;
              row_base <= row_base + ROW_STEP;
            end else begin
              oy       <= '0;
              row_base <= '0;
              if (!m_wrap) begin
                m        <= m + 1'b1;
                map_base <= map_base + MAP_STEP;
              end else begin
                m        <= '0;
                map_base <= '0;
              end
            end
          end
        end
      end
    end
  end

  // Registered read port; the tap flags travel with the read until its data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      iss_last_tap <= 1'b0;
      iss_last     <= 1'b0;
      rd_pend      <= 1'b0;
      arr_last_tap <= 1'b0;
      arr_last     <= 1'b0;
    end else begin
      ram_en_q     <= fire;
      if (fire) begin
        ram_addr_q   <= cur_addr;
        iss_last_tap <= cur_last_tap;
        iss_last     <= cur_last;
      end
      rd_pend      <= ram_en_q;
      arr_last_tap <= iss_last_tap;
      arr_last     <= iss_last;
    end
  end

  // 2-entry FIFO storing {last, last_tap, data} for data that could not bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) fifo_mem[wptr] <= {arr_last, arr_last_tap, bus.ram_dout};
      wptr     <= wptr ^ push;
      rptr     <= rptr ^ fifo_pop;
      fifo_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_stride2_window_reader.sv
// Directed bench for stride2_window_reader: a reference loop nest fills a
// scoreboard at each start, and every tap handshake pops and compares it.
module tb_stride2_window_reader;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 10;
  localparam int MAP_W    = 9;
  localparam int MAP_H    = 9;
  localparam int NUM_MAPS = 2;
  localparam int K        = 3;
  localparam int STRIDE   = 2;
  localparam int OW       = (MAP_W - K) / STRIDE + 1;
  localparam int OH       = (MAP_H - K) / STRIDE + 1;
  localparam int TAPS     = NUM_MAPS * OH * OW * K * K;
  localparam int MAX_ADDR = NUM_MAPS * MAP_W * MAP_H - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last_tap;
    logic              last;
  } tap_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  stride2_window_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  stride2_window_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAP_W(MAP_W), .MAP_H(MAP_H),
    .NUM_MAPS(NUM_MAPS), .K(K), .STRIDE(STRIDE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];
  end

  int   checks = 0;
  int   errors = 0;
  tap_t q[$];
  int   popped, issued, max_out, max_addr, nlast, last_pop_cyc, cyc, stall_cnt;
  logic [DATA_W+2:0] held;
  int   exp_w1[9];
  int   exp_w2[9];
  int   exp_wl[9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},         32'(busy),             0);
    chk({tag, "_done"},         32'(done),             0);
    chk({tag, "_ram_en"},       32'(bus.ram_en),       0);
    chk({tag, "_ram_addr"},     32'(bus.ram_addr),     0);
    chk({tag, "_win_data"},     32'(bus.win_data),     0);
    chk({tag, "_win_valid"},    32'(bus.win_valid),    0);
    chk({tag, "_win_last_tap"}, 32'(bus.win_last_tap), 0);
    chk({tag, "_win_last"},     32'(bus.win_last),     0);
  endtask

  // mode 0: ready high; 1: 5-cycle stall at tap 40; 2: random ready and
  // starts during busy; 3: ready high, return at tap 100 for a reset abort.
  task automatic run_pass(input int mode, input logic start_on_done);
    tap_t t;
    int   occ;
    bit   finished;
    logic [DATA_W+2:0] snap;
    for (int mm = 0; mm < NUM_MAPS; mm++)
      for (int oy = 0; oy < OH; oy++)
        for (int ox = 0; ox < OW; ox++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              t.data     = DATA_W'(mm * MAP_W * MAP_H + (oy * STRIDE + ky) * MAP_W + ox * STRIDE + kx);
              t.last_tap = (kx == K - 1) && (ky == K - 1);
              t.last     = t.last_tap && (ox == OW - 1) && (oy == OH - 1) && (mm == NUM_MAPS - 1);
              q.push_back(t);
            end
    popped = 0; issued = 0; max_out = 0; max_addr = 0; nlast = 0;
    last_pop_cyc = -10; stall_cnt = 0; finished = 0; cyc = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mode == 3 && popped == 100) return;
      if (done) begin
        finished = 1;
        start = start_on_done;
        chk("taps_transferred", popped, TAPS);
        chk("done_after_last", cyc, last_pop_cyc + 1);
        chk("busy_low_at_done", 32'(busy), 0);
        chk("queue_empty", q.size(), 0);
        chk("win_last_count", nlast, 1);
        chk("outstanding_le_2", 32'(max_out <= 2), 1);
        chk("max_ram_addr", max_addr, MAX_ADDR);
      end else begin
        start = (mode == 2 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (mode == 1 && popped == 40 && stall_cnt < 5) begin
          bus.win_ready = 1'b0;
          stall_cnt++;
        end else if (mode == 2) begin
          bus.win_ready = 1'($urandom_range(0, 1));
        end else begin
          bus.win_ready = 1'b1;
        end
        if (cyc == 1) begin
          chk("busy_after_start", 32'(busy), 1);
          chk("valid_low_cycle1", 32'(bus.win_valid), 0);
        end
        if (cyc == 2) chk("first_valid_cycle2", 32'(bus.win_valid), 1);
        if (mode == 1 && !bus.win_ready) begin
          snap = {bus.win_valid, bus.win_last, bus.win_last_tap, bus.win_data};
          if (stall_cnt == 1) begin
            held = snap;
            chk("stall_valid", 32'(bus.win_valid), 1);
          end else begin
            chk("stall_hold", 32'(snap), 32'(held));
          end
        end
        occ = issued - popped + (bus.ram_en ? 1 : 0);
        if (occ > max_out) max_out = occ;
        if (bus.ram_en) begin
          issued++;
          if (int'(bus.ram_addr) > max_addr) max_addr = int'(bus.ram_addr);
        end
        if (bus.win_valid && bus.win_ready) begin
          chk("tap_expected", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            t = q.pop_front();
            chk("tap_data", 32'(bus.win_data), 32'(t.data));
            chk("tap_last_tap", 32'(bus.win_last_tap), 32'(t.last_tap));
            chk("tap_last", 32'(bus.win_last), 32'(t.last));
            if (popped < 9) chk("win1_addr", 32'(bus.win_data), exp_w1[popped]);
            else if (popped < 18) chk("win2_addr", 32'(bus.win_data), exp_w2[popped - 9]);
            if (popped == 36) chk("win5_first", 32'(bus.win_data), 18);
            if (popped >= TAPS - 9 && popped < TAPS)
              chk("final_win_addr", 32'(bus.win_data), exp_wl[popped - (TAPS - 9)]);
          end
          if (bus.win_last) nlast++;
          last_pop_cyc = cyc;
          popped++;
        end
      end
    end
    chk("pass_finished", 32'(finished), 1);
    if (!finished) q.delete();
  endtask

  initial begin
    exp_w1 = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
    exp_w2 = '{2, 3, 4, 11, 12, 13, 20, 21, 22};
    exp_wl = '{141, 142, 143, 150, 151, 152, 159, 160, 161};
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
    rst_n = 1'b0;
    start = 1'b0;
    bus.win_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full pass with ready high; start held through the done cycle.
    start = 1'b1;
    run_pass(0, 1'b1);
    @(negedge clk);
    chk("start_at_done_ignored", 32'(busy), 0);
    chk("done_single_cycle", 32'(done), 0);

    // Start still high in the following cycle is accepted: stall pass.
    run_pass(1, 1'b0);
    @(negedge clk);
    chk("done_single_cycle_2", 32'(done), 0);

    // Random ready with start pulses while busy.
    start = 1'b1;
    run_pass(2, 1'b0);
    @(negedge clk);
    chk("random_starts_ignored", 32'(busy), 0);
    chk("done_single_cycle_3", 32'(done), 0);

    // Reset mid-pass at tap 100.
    start = 1'b1;
    run_pass(3, 1'b0);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_outputs_zero("abort");
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 0);
      chk("idle_after_abort", 32'(busy), 0);
    end

    // Restart after abort must begin at address 0 and complete.
    start = 1'b1;
    run_pass(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stride2_window_reader.md
STRIDE2_WINDOW_READER -- requirements
Module: stride2_window_reader

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DATA_W, 16, tap data width
  ADDR_W, 10, feature-map RAM address width
  MAP_W, 9, padded map width in words
  MAP_H, 9, padded map height in words
  NUM_MAPS, 2, maps stored back-to-back from address 0
  K, 3, square kernel size
  STRIDE, 2, window step in both axes
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse that begins a full pass over all maps
  busy  out  1  high from the cycle after an accepted start until done
  done  out  1  one-cycle pulse when the pass completes
  ram_en  out  1  read enable to RAM port A; write enable is tied low outside this block
  ram_addr  out  ADDR_W  read address to RAM port A
  ram_dout  in  DATA_W  RAM read data, valid one cycle after ram_en
  win_data  out  DATA_W  current tap value
  win_valid  out  1  win_data is valid
  win_ready  in  1  downstream accepts the tap
  win_last_tap  out  1  tap is the 9th (last) of its window
  win_last  out  1  tap is the final tap of the pass
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Output grid per map SHALL be OW=(MAP_W-K)/STRIDE+1 and OH=(MAP_H-K)/STRIDE+1, which is 4x4 at defaults.
REQ-005 Tap address SHALL be m*MAP_W*MAP_H + (oy*STRIDE+ky)*MAP_W + (ox*STRIDE+kx).
  Loop order, outer to inner: m, oy, ox, ky, kx.
  Total taps at defaults: 2*16*9 = 288.
REQ-006 Address arithmetic SHALL use counters and adders only, with no multipliers.
  Row base SHALL advance by STRIDE*MAP_W per oy step.
  Map base SHALL advance by MAP_W*MAP_H per m step.
REQ-007 FSM states SHALL be IDLE, FETCH, DRAIN.
  IDLE->FETCH on start.
  FETCH->DRAIN the cycle the 288th read is issued.
  DRAIN->IDLE when the 288th tap handshakes.
REQ-008 start SHALL be ignored while busy=1.
REQ-009 Output SHALL be buffered by a 2-entry FIFO.
  A read SHALL be issued (ram_en=1) only when FIFO occupancy + reads in flight < 2.
  No tap SHALL be dropped or duplicated under any win_ready pattern.
REQ-010 A tap SHALL transfer when win_valid=1 and win_ready=1.
  While win_valid=1 and win_ready=0, win_data, win_last_tap and win_last SHALL hold.
REQ-011 With win_ready held high, the block SHALL sustain one tap per cycle.
  First win_valid SHALL rise 2 cycles after the start cycle (start, issue, data).
REQ-012 win_last_tap SHALL be high for kx=K-1 and ky=K-1.
  win_last SHALL be high only on tap 288 and SHALL coincide with win_last_tap.
REQ-013 done SHALL pulse for one cycle, in the cycle after the 288th tap handshake.
  busy SHALL fall in the same cycle that done pulses.
REQ-014 A start that arrives in the same cycle as done SHALL be ignored.
  A start in the following cycle SHALL be accepted.
REQ-015 ram_addr SHALL never exceed NUM_MAPS*MAP_W*MAP_H-1 (161 at defaults).

Reset
REQ-016 On rst_n=0, all counters SHALL clear and the FSM SHALL return to IDLE.
  FIFO and in-flight tracking SHALL be emptied.
  Outputs SHALL be 0: busy, done, ram_en, ram_addr, win_data, win_valid, win_last_tap, win_last.
REQ-017 Reset asserted mid-pass SHALL abort the pass with no done pulse.
  The next start after release SHALL restart at address 0.

Verification
REQ-018 A bench SHALL cover the following scenarios:
  - start, win_ready=1 -> first 9 addresses 0,1,2,9,10,11,18,19,20; win_valid first high at cycle 2; win_last_tap on tap 9.
  - Same run, second window -> addresses 2,3,4,11,12,13,20,21,22; fifth window (oy=1, ox=0) starts at address 18.
  - Full pass with RAM preloaded ram[i]=i -> 288 taps; final window 141,142,143,150,151,152,159,160,161; win_last on tap 288 only; done one cycle later; busy low.
  - win_ready low for 5 cycles at tap 40 -> win_data held; at most 2 reads outstanding; tap sequence identical to the unstalled run.
  - Random win_ready at 50% -> 288 taps in order, no loss or duplication; start pulses during busy ignored.
  - rst_n low at tap 100 -> all outputs 0 asynchronously, no done; next start restarts at address 0 and completes 288 taps.
